// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB over a shared memory port.
// Latency (zero-wait memory): j/jal 2, beq/bne/jr/jalr 3, R/ALU-imm/store 4, load 5 cycles.
// Backpressure: Mem_Req is held until Mem_Ready; WAIT_MAX unanswered cycles trap into ERR until reset.
module multicycle_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             Mem_Ready,
    output logic             Mem_Req,
    output logic             Mem_Write,
    output logic             Mem_Is_Instr,
    output logic             IR_Write,
    output logic             Reg_Write,
    output logic             PC_Write,
    output logic             Branch_Taken,
    output logic             Jump_Reg,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] Instr_Count,
    output logic             Bus_Err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;

    logic is_rtype, is_j, is_jal, is_beq, is_bne, is_alui, is_load, is_store, is_known;

    logic mem_req_c, mem_write_c, mem_is_instr_c, ir_write_c, reg_write_c;
    logic pc_write_c, branch_taken_c, jump_reg_c;
    logic stalled;

    always_comb begin
        is_rtype = (opcode == 6'h00);
        is_j     = (opcode == 6'h02);
        is_jal   = (opcode == 6'h03);
        is_beq   = (opcode == 6'h04);
        is_bne   = (opcode == 6'h05);
        is_alui  = (opcode[5:3] == 3'b001);
        is_load  = (opcode == 6'h20) || (opcode == 6'h21) || (opcode == 6'h23) ||
                   (opcode == 6'h24) || (opcode == 6'h25);
        is_store = (opcode == 6'h28) || (opcode == 6'h29) || (opcode == 6'h2B);
        is_known = is_rtype || is_j || is_jal || is_beq || is_bne ||
                   is_alui || is_load || is_store;
    end

    always_comb begin
        state_nxt      = state;
        mem_req_c      = 1'b0;
        mem_write_c    = 1'b0;
        mem_is_instr_c = 1'b0;
        ir_write_c     = 1'b0;
        reg_write_c    = 1'b0;
        pc_write_c     = 1'b0;
        branch_taken_c = 1'b0;
        jump_reg_c     = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req_c      = 1'b1;
                mem_is_instr_c = 1'b1;
                if (Mem_Ready) begin
                    ir_write_c = 1'b1;
                    state_nxt  = S_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_ERR;
                end
            end
            S_DECODE: begin
                if (is_j || is_jal || !is_known) begin
                    // Unknown opcodes retire here as a nop so the PC keeps moving.
                    pc_write_c  = 1'b1;
                    reg_write_c = is_jal;
                    state_nxt   = S_FETCH;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_rtype && (Funct == 6'h08 || Funct == 6'h09)) begin
                    jump_reg_c  = 1'b1;
                    reg_write_c = Funct[0];
                    pc_write_c  = 1'b1;
                    state_nxt   = S_FETCH;
                end else if (is_rtype || is_alui) begin
                    state_nxt = S_WB;
                end else if (is_beq || is_bne) begin
                    pc_write_c     = 1'b1;
                    branch_taken_c = is_beq ? Zero : !Zero;
                    state_nxt      = S_FETCH;
                end else if (is_load || is_store) begin
                    state_nxt = S_MEM;
                end else begin
                    pc_write_c = 1'b1;
                    state_nxt  = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req_c   = 1'b1;
                mem_write_c = is_store;
                if (Mem_Ready) begin
                    if (is_store) begin
                        pc_write_c = 1'b1;
                        state_nxt  = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_ERR;
                end
            end
            S_WB: begin
                reg_write_c = 1'b1;
                pc_write_c  = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_ERR: begin
                state_nxt = S_ERR;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    assign stalled = mem_req_c && !Mem_Ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_FETCH;
            wait_cnt    <= 8'd0;
            Instr_Count <= '0;
            Bus_Err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                wait_cnt <= 8'd0;
            end else if (stalled) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (pc_write_c) begin
                Instr_Count <= Instr_Count + CNT_W'(1);
            end
            if (state_nxt == S_ERR) begin
                Bus_Err <= 1'b1;
            end
        end
    end

    // Strobes are gated by reset so nothing leaks out while the core is held.
    assign Mem_Req      = mem_req_c      & rst;
    assign Mem_Write    = mem_write_c    & rst;
    assign Mem_Is_Instr = mem_is_instr_c & rst;
    assign IR_Write     = ir_write_c     & rst;
    assign Reg_Write    = reg_write_c    & rst;
    assign PC_Write     = pc_write_c     & rst;
    assign Branch_Taken = branch_taken_c & rst;
    assign Jump_Reg     = jump_reg_c     & rst;
    assign State        = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected retirements queued by stimulus, popped by a monitor on PC_Write.
module tb_multicycle_ctrl;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [5:0]       opcode;
    logic [5:0]       Funct;
    logic             Zero;
    logic             Mem_Ready;
    logic             Mem_Req, Mem_Write, Mem_Is_Instr, IR_Write, Reg_Write;
    logic             PC_Write, Branch_Taken, Jump_Reg;
    logic [2:0]       State;
    logic [CNT_W-1:0] Instr_Count;
    logic             Bus_Err;

    multicycle_ctrl #(.WAIT_MAX(15), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .Funct(Funct), .Zero(Zero),
        .Mem_Ready(Mem_Ready), .Mem_Req(Mem_Req), .Mem_Write(Mem_Write),
        .Mem_Is_Instr(Mem_Is_Instr), .IR_Write(IR_Write), .Reg_Write(Reg_Write),
        .PC_Write(PC_Write), .Branch_Taken(Branch_Taken), .Jump_Reg(Jump_Reg),
        .State(State), .Instr_Count(Instr_Count), .Bus_Err(Bus_Err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int rw;
        int bt;
        int jr;
        int lat;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;
    int   ilen = 0;
    int   fetch_wait = 0;
    int   data_wait = 0;
    int   wleft = 0;
    bit   req_open = 1'b0;
    int   st_tr[64], rw_tr[64], pcw_tr[64], irw_tr[64], mw_tr[64];
    int   mreq_tr[64], bt_tr[64], err_tr[64], any_tr[64];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Memory model: answers after the programmed number of wait cycles.
    task automatic mem_eval();
        if (!Mem_Req) begin
            req_open = 1'b0;
        end else if (!req_open) begin
            req_open = 1'b1;
            wleft    = Mem_Is_Instr ? fetch_wait : data_wait;
        end
        Mem_Ready = req_open && (wleft == 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (req_open) begin
            if (Mem_Ready) req_open = 1'b0;
            else if (wleft > 0) wleft--;
        end
        mem_eval();
    endtask

    task automatic record(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            st_tr[k]   = int'(State);
            rw_tr[k]   = int'(Reg_Write);
            pcw_tr[k]  = int'(PC_Write);
            irw_tr[k]  = int'(IR_Write);
            mw_tr[k]   = int'(Mem_Write);
            mreq_tr[k] = int'(Mem_Req);
            bt_tr[k]   = int'(Branch_Taken);
            err_tr[k]  = int'(Bus_Err);
            any_tr[k]  = int'(Mem_Req | Mem_Write | Mem_Is_Instr | IR_Write | Reg_Write |
                              PC_Write | Branch_Taken | Jump_Reg);
            tick();
        end
    endtask

    task automatic start_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                               input int fw, input int dw);
        opcode     = op;
        Funct      = fn;
        Zero       = z;
        fetch_wait = fw;
        data_wait  = dw;
        #1;
        req_open = 1'b0;
        mem_eval();
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int dw, input int base,
                       input int rw, input int bt, input int jr);
        exp_t e;
        e.rw  = rw;
        e.bt  = bt;
        e.jr  = jr;
        e.lat = base + fw + dw;
        e.cnt = model_cnt;
        exp_q.push_back(e);
        model_cnt = (model_cnt + 1) % (1 << CNT_W);
        start_instr(op, fn, z, fw, dw);
        record(base + fw + dw);
    endtask

    function automatic int sum_tr(input int which, input int lo, input int hi);
        int s = 0;
        for (int k = lo; k <= hi; k++) begin
            case (which)
                0: s += mw_tr[k];
                1: s += rw_tr[k];
                2: s += mreq_tr[k];
                3: s += pcw_tr[k];
                4: s += mreq_tr[k] & mw_tr[k];
                default: s += any_tr[k];
            endcase
        end
        return s;
    endfunction

    // Monitor: every retirement must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            ilen = 0;
        end else begin
            ilen++;
            if (PC_Write) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("retire_reg_write", int'(Reg_Write), mon_e.rw);
                    chk("retire_branch_taken", int'(Branch_Taken), mon_e.bt);
                    chk("retire_jump_reg", int'(Jump_Reg), mon_e.jr);
                    chk("retire_latency", ilen, mon_e.lat);
                    chk("retire_count_before", int'(Instr_Count), mon_e.cnt);
                end
                ilen = 0;
            end else if (Reg_Write) begin
                chk("reg_write_without_retire", 1, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        opcode    = 6'h00;
        Funct     = 6'h00;
        Zero      = 1'b0;
        Mem_Ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", int'(State), 0);
        chk("reset_count", int'(Instr_Count), 0);
        chk("reset_bus_err", int'(Bus_Err), 0);
        chk("reset_strobes", int'(Mem_Req | IR_Write | Reg_Write | PC_Write), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // T1: R-type add, zero-wait memory
        run(6'h00, 6'h20, 1'b0, 0, 0, 4, 1, 0, 0);
        chk("t1_state_c0", st_tr[0], 0);
        chk("t1_state_c1", st_tr[1], 1);
        chk("t1_state_c2", st_tr[2], 2);
        chk("t1_state_c3", st_tr[3], 4);
        chk("t1_state_after", int'(State), 0);
        chk("t1_ir_write_c0", irw_tr[0], 1);
        chk("t1_rw_pcw_c3", rw_tr[3] & pcw_tr[3], 1);
        chk("t1_count", int'(Instr_Count), 1);

        // T2: lw, 3 fetch waits and 2 data waits -> 10 cycles
        run(6'h23, 6'h00, 1'b0, 3, 2, 5, 1, 0, 0);
        chk("t2_mem_write_cycles", sum_tr(0, 0, 9), 0);
        chk("t2_reg_write_cycles", sum_tr(1, 0, 9), 1);
        chk("t2_reg_write_in_wb", rw_tr[9] & int'(st_tr[9] == 4), 1);
        chk("t2_mem_req_cycles", sum_tr(2, 0, 9), 7);

        // T3: beq/bne with Zero=1, then with Zero=0
        run(6'h04, 6'h00, 1'b1, 0, 0, 3, 0, 1, 0);
        chk("t3_beq_pcw_once", sum_tr(3, 0, 2), 1);
        run(6'h05, 6'h00, 1'b1, 0, 0, 3, 0, 0, 0);
        chk("t3_bne_pcw_once", sum_tr(3, 0, 2), 1);
        run(6'h04, 6'h00, 1'b0, 0, 0, 3, 0, 0, 0);
        run(6'h05, 6'h00, 1'b0, 0, 0, 3, 0, 1, 0);

        // Remaining instruction classes
        run(6'h00, 6'h08, 1'b0, 0, 0, 3, 0, 0, 1);  // jr
        run(6'h00, 6'h09, 1'b0, 0, 0, 3, 1, 0, 1);  // jalr
        run(6'h02, 6'h00, 1'b0, 0, 0, 2, 0, 0, 0);  // j
        run(6'h08, 6'h00, 1'b0, 0, 0, 4, 1, 0, 0);  // addi
        run(6'h0F, 6'h00, 1'b0, 0, 0, 4, 1, 0, 0);  // lui
        run(6'h3F, 6'h00, 1'b0, 0, 0, 2, 0, 0, 0);  // unknown opcode
        run(6'h2B, 6'h00, 1'b0, 0, 1, 4, 0, 0, 0);  // sw with one data wait
        chk("sw_mem_write_cycles", sum_tr(4, 0, 4), 2);
        chk("sw_data_port", mreq_tr[3] & int'(st_tr[3] == 3), 1);

        // T5: reset in the middle of a stalled lw
        start_instr(6'h23, 6'h00, 1'b0, 0, 1000);
        record(5);
        chk("t5_in_mem", st_tr[4], 3);
        rst = 1'b0;
        #1;
        chk("t5_strobes_drop", int'(Mem_Req | Mem_Is_Instr | Reg_Write | PC_Write), 0);
        chk("t5_state", int'(State), 0);
        chk("t5_count", int'(Instr_Count), 0);
        model_cnt = 0;
        tick();
        tick();
        rst = 1'b1;
        run(6'h00, 6'h22, 1'b0, 0, 0, 4, 1, 0, 0);
        chk("t5_count_after_restart", int'(Instr_Count), 1);

        // T6: 17 back-to-back jal from a fresh reset -> 4-bit count wraps to 1
        rst = 1'b0;
        tick();
        model_cnt = 0;
        rst = 1'b1;
        for (int i = 0; i < 17; i++) begin
            run(6'h03, 6'h00, 1'b0, 0, 0, 2, 1, 0, 0);
            chk("t6_decode_rw_pcw", rw_tr[1] & pcw_tr[1] & int'(st_tr[1] == 1), 1);
        end
        chk("t6_count_wrap", int'(Instr_Count), 1);

        // T4: sw never answered -> 15 request cycles, then ERR
        start_instr(6'h2B, 6'h00, 1'b0, 0, 1000);
        record(22);
        chk("t4_req_write_cycles", sum_tr(4, 0, 21), 15);
        chk("t4_last_req_cycle", mreq_tr[17], 1);
        chk("t4_bus_err_before", err_tr[17], 0);
        chk("t4_err_state", st_tr[18], 7);
        chk("t4_bus_err", err_tr[18], 1);
        chk("t4_err_strobes", sum_tr(5, 18, 21), 0);
        chk("t4_err_held", st_tr[21], 7);
        chk("t4_count_unchanged", int'(Instr_Count), 1);
        rst = 1'b0;
        #1;
        chk("t4_reset_bus_err", int'(Bus_Err), 0);
        chk("t4_reset_state", int'(State), 0);
        tick();
        model_cnt = 0;
        rst = 1'b1;
        run(6'h02, 6'h00, 1'b0, 0, 0, 2, 0, 0, 0);
        chk("recovery_count", int'(Instr_Count), 1);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
